// File: rtl/mem_io_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Purpose  : Byte-bus responder for the CPU: RAM plus the I/O window at 0x30000.
// Revision : 1.0
// ============================================================================
module mem_io_responder #(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_pop,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(TX_DEPTH);
    localparam logic [CNT_W-1:0] C_MARGIN = CNT_W'(FULL_MARGIN);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    // Storage arrays (never reset)
    logic [7:0] ram_q  [2**RAM_ADDR_W];
    logic [7:0] fifo_q [TX_DEPTH];
    logic [7:0] ram_rdata_q;

    // Registered state
    logic             rd_src_ram_q, rd_src_ram_d;
    logic [7:0]       io_rdata_q,   io_rdata_d;
    logic [31:0]      snap_q,       snap_d;
    logic [31:0]      cycle_q,      cycle_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic             iobf_q,       iobf_d;
    logic             rx_pop_q,     rx_pop_d;
    logic             stop_q,       stop_d;
    logic             ovf_q,        ovf_d;

    // Decode
    logic                  w_is_io;
    logic [15:0]           w_io_off;
    logic [RAM_ADDR_W-1:0] w_ram_addr;
    logic                  w_ram_wr, w_ram_rd, w_io_rd, w_io_wr;
    logic                  w_push, w_pop, w_push_ok, w_full;
    logic [7:0]            w_push_data;
    logic                  w_unused_addr;

    assign w_is_io       = (mem_a[17:16] == 2'b11);
    assign w_io_off      = mem_a[15:0];
    assign w_ram_addr    = mem_a[RAM_ADDR_W-1:0];
    assign w_unused_addr = ^mem_a[31:18];

    assign w_ram_wr = rdy_in &  mem_wr & ~w_is_io;
    assign w_ram_rd = rdy_in & ~mem_wr & ~w_is_io;
    assign w_io_rd  = rdy_in & ~mem_wr &  w_is_io;
    // Once stopped, the I/O write path is closed; RAM remains reachable.
    assign w_io_wr  = rdy_in &  mem_wr &  w_is_io & ~stop_q;

    always_ff @(posedge clk_in) begin
        if (w_ram_wr) ram_q[w_ram_addr] <= mem_dout;
        if (w_ram_rd) ram_rdata_q       <= ram_q[w_ram_addr];
    end

    always_ff @(posedge clk_in) begin
        if (w_push_ok) fifo_q[wr_ptr_q] <= w_push_data;
    end

    always_comb begin
        rd_src_ram_d = rd_src_ram_q;
        io_rdata_d   = io_rdata_q;
        snap_d       = snap_q;
        rx_pop_d     = 1'b0;
        stop_d       = stop_q;
        w_push       = 1'b0;
        w_push_data  = 8'h00;

        if (w_ram_rd) rd_src_ram_d = 1'b1;

        if (w_io_rd) begin
            rd_src_ram_d = 1'b0;
            case (w_io_off)
                16'h0000: begin
                    io_rdata_d = rx_empty ? 8'h00 : rx_data;
                    rx_pop_d   = ~rx_empty;
                end
                // Byte 0 latches the live counter so bytes 1..3 come from the same value.
                16'h0004: begin
                    snap_d     = cycle_q;
                    io_rdata_d = cycle_q[7:0];
                end
                16'h0005: io_rdata_d = snap_q[15:8];
                16'h0006: io_rdata_d = snap_q[23:16];
                16'h0007: io_rdata_d = snap_q[31:24];
                default:  io_rdata_d = 8'h00;
            endcase
        end

        if (w_io_wr) begin
            case (w_io_off)
                16'h0000: begin
                    w_push      = (mem_dout != 8'h00);
                    w_push_data = mem_dout;
                end
                16'h0004: begin
                    w_push      = 1'b1;
                    w_push_data = 8'h00;
                    stop_d      = 1'b1;
                end
                default: w_push = 1'b0;
            endcase
        end
    end

    // TX FIFO bookkeeping; a pop in the same cycle frees room for a push when full.
    always_comb begin
        w_pop     = (count_q != '0) & tx_ready;
        w_full    = (count_q == C_DEPTH);
        w_push_ok = w_push & (~w_full | w_pop);
        ovf_d     = ovf_q | (w_push & ~w_push_ok);
        wr_ptr_d  = w_push_ok ? wr_ptr_q + C_PTR_ONE : wr_ptr_q;
        rd_ptr_d  = w_pop     ? rd_ptr_q + C_PTR_ONE : rd_ptr_q;
        count_d   = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        iobf_d    = ((C_DEPTH - count_d) <= C_MARGIN);
        cycle_d   = cycle_q + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_src_ram_q <= 1'b0;
            io_rdata_q   <= 8'h00;
            snap_q       <= 32'h0;
            cycle_q      <= 32'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            iobf_q       <= 1'b0;
            rx_pop_q     <= 1'b0;
            stop_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            rd_src_ram_q <= rd_src_ram_d;
            io_rdata_q   <= io_rdata_d;
            snap_q       <= snap_d;
            cycle_q      <= cycle_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            iobf_q       <= iobf_d;
            rx_pop_q     <= rx_pop_d;
            stop_q       <= stop_d;
            ovf_q        <= ovf_d;
        end
    end

    assign mem_din        = rd_src_ram_q ? ram_rdata_q : io_rdata_q;
    assign tx_data        = fifo_q[rd_ptr_q];
    assign tx_valid       = (count_q != '0);
    assign io_buffer_full = iobf_q;
    assign rx_pop         = rx_pop_q;
    assign program_stop   = stop_q;
    assign tx_overflow    = ovf_q;

endmodule
`default_nettype wire
